// File: rtl/twinkle_player.sv
// Plays "Twinkle Twinkle Little Star" (42 notes) by gating tone clocks onto a speaker pin.
// Define LOOP_EN to restart the melody directly after the last note while play stays high.
module twinkle_player #(
  parameter int BEAT_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play,
  input  logic [7:0] note_clk,
  output logic       spk,
  output logic [5:0] note_idx,
  output logic [2:0] note_code,
  output logic       busy,
  output logic       done
);

  localparam logic [28:0] ONE_BEAT = 29'(BEAT_CYCLES);
  localparam logic [28:0] TWO_BEAT = 29'(2 * BEAT_CYCLES);
  localparam logic [28:0] GAP_LEN  = 29'(GAP_CYCLES);

  // Each entry is {code[2:0], len}; the seventh note of every phrase is held for two beats.
  localparam logic [3:0] MELODY [42] = '{
    4'h0, 4'h0, 4'h8, 4'h8, 4'hA, 4'hA, 4'h9,
    4'h6, 4'h6, 4'h4, 4'h4, 4'h2, 4'h2, 4'h1,
    4'h8, 4'h8, 4'h6, 4'h6, 4'h4, 4'h4, 4'h3,
    4'h8, 4'h8, 4'h6, 4'h6, 4'h4, 4'h4, 4'h3,
    4'h0, 4'h0, 4'h8, 4'h8, 4'hA, 4'hA, 4'h9,
    4'h6, 4'h6, 4'h4, 4'h4, 4'h2, 4'h2, 4'h1
  };

  typedef enum logic [1:0] {IDLE, TONE, GAP, FINISH} state_t;

  state_t      state;
  logic [28:0] cnt;
  logic [3:0]  cur_entry;
  logic [28:0] note_len;
  logic [28:0] tone_end;
  logic [28:0] note_end;
  logic        last_note;

  assign cur_entry = MELODY[note_idx];
  assign note_code = cur_entry[3:1];
  assign note_len  = cur_entry[0] ? TWO_BEAT : ONE_BEAT;
  assign tone_end  = note_len - GAP_LEN - 29'd1;
  assign note_end  = note_len - 29'd1;
  assign last_note = (note_idx == 6'd41);

  // The end of the final note wins over a simultaneous play drop so done is never lost there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      note_idx <= '0;
      cnt      <= '0;
      spk      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          note_idx <= '0;
          cnt      <= '0;
          if (play) begin
            state <= TONE;
            busy  <= 1'b1;
            spk   <= note_clk[MELODY[0][3:1]];
          end else begin
            busy <= 1'b0;
            spk  <= 1'b0;
          end
        end

        TONE, GAP: begin
          if (state == GAP && cnt == note_end && last_note) begin
            done <= 1'b1;
            cnt  <= '0;
`ifdef LOOP_EN
            note_idx <= '0;
            if (play) begin
              state <= TONE;
              busy  <= 1'b1;
              spk   <= note_clk[MELODY[0][3:1]];
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              spk   <= 1'b0;
            end
`else
            state <= FINISH;
            busy  <= 1'b0;
            spk   <= 1'b0;
`endif
          end else if (!play) begin
            state    <= IDLE;
            note_idx <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            spk      <= 1'b0;
          end else if (state == GAP && cnt == note_end) begin
            state    <= TONE;
            note_idx <= note_idx + 6'd1;
            cnt      <= '0;
            spk      <= note_clk[MELODY[note_idx + 6'd1][3:1]];
          end else if (state == TONE && cnt == tone_end) begin
            state <= GAP;
            cnt   <= cnt + 29'd1;
            spk   <= 1'b0;
          end else begin
            cnt <= cnt + 29'd1;
            spk <= (state == TONE) ? note_clk[cur_entry[3:1]] : 1'b0;
          end
        end

        FINISH: begin
          spk  <= 1'b0;
          busy <= 1'b0;
          if (!play) begin
            state    <= IDLE;
            note_idx <= '0;
            cnt      <= '0;
          end
        end

        default: begin
          state    <= IDLE;
          note_idx <= '0;
          cnt      <= '0;
          spk      <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
